// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 50 MHz clock, 3-bit baud select, framing-error strobe.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [2:0] bps,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_d;
  logic [12:0]            cnt;
  logic [12:0]            div_q;
  logic [12:0]            div_sel;
  logic [12:0]            half;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;

  logic start_det;
  logic hit;
  logic sample;
  logic latch_div;
  logic shift_en;
  logic good_stop;
  logic bad_stop;

  // Synchronizer idles high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      rx_d <= rx_s;
    end
  end

  assign rx_s      = sync[SYNC_STAGES-1];
  assign start_det = rx_d && !rx_s;
  assign half      = div_q >> 1;

  always_comb begin
    div_sel = 13'd5208;
    case (bps)
      3'b000:  div_sel = 13'd5208;
      3'b001:  div_sel = 13'd2603;
      3'b010:  div_sel = 13'd1301;
      3'b011:  div_sel = 13'd867;
      3'b100:  div_sel = 13'd433;
      default: div_sel = 13'd5208;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    case (state)
      ST_START:         hit = (cnt == half);
      ST_DATA, ST_STOP: hit = (cnt == div_q);
      default:          hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_det) state_next = ST_START;
      ST_START: if (hit) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (hit && bit_idx == 3'd7) state_next = ST_STOP;
      ST_STOP:  if (hit) state_next = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    latch_div = (state == ST_IDLE) && start_det;
    sample    = hit;
    shift_en  = (state == ST_DATA) && hit;
    good_stop = (state == ST_STOP) && hit && rx_s;
    bad_stop  = (state == ST_STOP) && hit && !rx_s;
  end

  // Divisor is captured once per frame so a bps change mid-frame is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      div_q     <= 13'd5208;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= good_stop;
      frame_err <= bad_stop;
      if (state_next != state || sample) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 13'd1;
      end
      if (latch_div) begin
        div_q <= div_sel;
      end
      if (state == ST_START && hit) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) begin
        shift <= {rx_s, shift[7:1]};
      end
      if (good_stop) begin
        data <= shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx: serial frames in, strobe timing and bytes checked.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [2:0] bps = 3'b100;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .bps       (bps),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int div_of(input logic [2:0] sel);
    case (sel)
      3'b000:  return 5208;
      3'b001:  return 2603;
      3'b010:  return 1301;
      3'b011:  return 867;
      3'b100:  return 433;
      default: return 5208;
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobes are popped from the scoreboard and checked for kind, exact cycle and byte.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, frame_err, valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", {30'd0, frame_err, valid}, e.err ? 32'd2 : 32'd1);
        check("strobe_cycle", cyc, e.at);
        if (e.err) begin
          check("err_data_held", {24'd0, data}, {24'd0, model_data});
        end else begin
          model_data = e.b;
          check("rx_data", {24'd0, data}, {24'd0, e.b});
          check("busy_after_stop", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  // Drives one frame starting now; sw_bit/rst_bit (0..7, or -1) switch bps or pulse reset before that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low,
                            input int sw_bit, input int rst_bit);
    int   d;
    int   t0;
    exp_t e;
    d  = div_of(bps);
    rx = 1'b0;
    t0 = cyc;
    e.err = !stop;
    e.b   = b;
    e.at  = t0 + 3 + (d >> 1) + 1 + 9 * (d + 1);
    if (rst_bit < 0) sb.push_back(e);
    wait_cyc(d + 1);
    for (int k = 0; k < 8; k++) begin
      if (k == sw_bit) bps = 3'b000;
      if (k == rst_bit) begin
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        model_data = 8'h00;
        rx = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(2 * (d + 1));
        return;
      end
      rx = b[k];
      wait_cyc(d + 1);
    end
    rx = stop;
    wait_cyc(d + 1);
    if (!stop) begin
      wait_cyc(extra_low);
      check("busy_in_break", {31'd0, busy}, 32'd1);
    end
    rx = 1'b1;
  endtask

  initial begin
    int t0;
    int n;
    rst_n = 1'b0;
    wait_cyc(3);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Framing error with 3 bit times of low line, then a good frame.
    bps = 3'b011;
    send_frame(8'h3C, 1'b0, 2 * 868, -1, -1);
    wait_cyc(868);
    send_frame(8'h81, 1'b1, 0, -1, -1);
    wait_cyc(868);

    // Loopback-style single frame at 115200.
    bps = 3'b100;
    send_frame(8'hA5, 1'b1, 0, -1, -1);
    wait_cyc(434);

    // Back-to-back frames, one stop bit apart.
    bps = 3'b011;
    send_frame(8'h00, 1'b1, 0, -1, -1);
    send_frame(8'hFF, 1'b1, 0, -1, -1);
    send_frame(8'h55, 1'b1, 0, -1, -1);
    wait_cyc(868);

    // Reset pulsed during data bit 4, then a clean frame.
    bps = 3'b100;
    send_frame(8'hF0, 1'b1, 0, -1, 4);
    send_frame(8'h0F, 1'b1, 0, -1, -1);
    wait_cyc(434);

    // bps switched to 9600 mid-frame: this frame stays at 115200.
    bps = 3'b100;
    send_frame(8'h5A, 1'b1, 0, 2, -1);
    wait_cyc(434);

    // A 1000-clock glitch at 9600 must be rejected at the start sample.
    rx = 1'b0;
    t0 = cyc;
    wait_cyc(1000);
    rx = 1'b1;
    wait_cyc(t0 + 2607 - cyc);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_cyc(1);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    wait_cyc(3000);

    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      wait_cyc(1);
      n++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
